// File: rtl/mul_pkg.sv
// Shared constants and FSM state encoding for the repeated-addition multiplier.
package mul_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage : mul_pkg

// File: rtl/mul_datapath.sv
// Operand/product registers for the multiplier: A, down-counting B, accumulating P.
module mul_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             ld_a_i,
  input  logic             ld_b_i,
  input  logic             dec_b_i,
  input  logic             ld_p_i,
  input  logic             clr_p_i,
  output logic             eqz_o,
  output logic [WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] sum;

  // Truncating adder: the product wraps modulo 2^WIDTH with no overflow flag.
  assign sum = p_q + a_q;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    if (ld_a_i) a_d = data_in_i;
    if (ld_b_i) b_d = data_in_i;
    else if (dec_b_i) b_d = b_q - 1'b1;
    if (clr_p_i) p_d = '0;
    else if (ld_p_i) p_d = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign eqz_o     = (b_q == '0);
  assign product_o = p_q;

endmodule : mul_datapath

// File: rtl/mul_top.sv
// Sequential unsigned multiplier: serially loads A then B, adds A into P B times.
module mul_top
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output state_t           dbg_state_o
);

  // Handshake: start is a single-cycle request honoured only in IDLE or DONE;
  // the next two cycles take A then B from data_in, and done stays high in
  // DONE until the following start is sampled.
  state_t state_q, state_d;
  logic   ld_a, ld_b, dec_b, ld_p, clr_p;
  logic   eqz;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    dec_b   = 1'b0;
    ld_p    = 1'b0;
    clr_p   = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD_A;
      LOAD_A: begin
        ld_a    = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        ld_b    = 1'b1;
        clr_p   = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        if (eqz) begin
          state_d = DONE;
        end else begin
          ld_p  = 1'b1;
          dec_b = 1'b1;
        end
      end
      DONE: if (start) state_d = LOAD_A;
      default: state_d = IDLE;
    endcase
  end

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .data_in_i (data_in),
    .ld_a_i    (ld_a),
    .ld_b_i    (ld_b),
    .dec_b_i   (dec_b),
    .ld_p_i    (ld_p),
    .clr_p_i   (clr_p),
    .eqz_o     (eqz),
    .product_o (product)
  );

  assign done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule : mul_top

// File: tb/tb_mul_top.sv
// Directed bench for mul_top: latency, zero operands, wrap, busy start, mid-op reset.
module tb_mul_top;
  import mul_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         done;
  logic [W-1:0] product;
  state_t       dbg_state;

  int n_checks;
  int n_fail;

  mul_top #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .done        (done),
    .product     (product),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 ns after the edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // start sampled at edge k, A latched at k+1, B latched at k+2
  task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    tick(1);
    start   = 1'b0;
    data_in = a;
    tick(1);
    data_in = b;
    tick(1);
    data_in = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    data_in = 16'hFFFF;
    tick(2);
    rst = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %0b expected 0", done);
    end
    n_checks++;
    if (product !== 16'd0) begin
      n_fail++; $display("FAIL reset_product: got %0d expected 0", product);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    tick(3);
    n_checks++;
    if (dbg_state !== IDLE || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: state %0d done %0b expected IDLE/0", dbg_state, done);
    end
  endtask

  task automatic test_basic;
    int drops;
    load_ops(16'd9, 16'd4);
    tick(4);  // edge k+6
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_done: got %0b expected 0 at k+6", done);
    end
    tick(1);  // edge k+7
    n_checks++;
    if (done !== 1'b1 || product !== 16'd36) begin
      n_fail++; $display("FAIL basic_result: done %0b product %0d expected 1/36", done, product);
    end
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (done !== 1'b1 || product !== 16'd36) drops++;
    end
    n_checks++;
    if (drops !== 0) begin
      n_fail++; $display("FAIL basic_hold: %0d bad cycles expected 0", drops);
    end
  endtask

  task automatic test_zero_operands;
    load_ops(16'd7, 16'd0);  // edge k+2, in CALC
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL b0_early_done: got %0b expected 0", done);
    end
    tick(1);  // edge k+3
    n_checks++;
    if (done !== 1'b1 || product !== 16'd0) begin
      n_fail++; $display("FAIL b0_result: done %0b product %0d expected 1/0", done, product);
    end
    load_ops(16'd0, 16'd5);
    tick(5);  // edge k+7
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL a0_early_done: got %0b expected 0", done);
    end
    tick(1);  // edge k+8
    n_checks++;
    if (done !== 1'b1 || product !== 16'd0) begin
      n_fail++; $display("FAIL a0_result: done %0b product %0d expected 1/0", done, product);
    end
  endtask

  task automatic test_overflow;
    load_ops(16'd300, 16'd300);
    tick(301);
    n_checks++;
    if (done !== 1'b1 || product !== 16'd24464) begin
      n_fail++; $display("FAIL overflow: done %0b product %0d expected 1/24464", done, product);
    end
  endtask

  task automatic test_start_while_busy;
    load_ops(16'd3, 16'd10);
    tick(4);
    start   = 1'b1;
    data_in = 16'd77;
    tick(1);
    start   = 1'b0;
    data_in = '0;
    tick(5);  // edge k+12
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL busy_early_done: got %0b expected 0", done);
    end
    tick(1);  // edge k+13
    n_checks++;
    if (done !== 1'b1 || product !== 16'd30) begin
      n_fail++; $display("FAIL busy_result: done %0b product %0d expected 1/30", done, product);
    end
    start = 1'b1;
    tick(1);  // start sampled in DONE
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || dbg_state !== LOAD_A) begin
      n_fail++; $display("FAIL restart_drop: done %0b state %0d expected 0/LOAD_A", done, dbg_state);
    end
    data_in = 16'd5;
    tick(1);
    data_in = 16'd6;
    tick(1);
    data_in = '0;
    n_checks++;
    if (product !== 16'd0) begin
      n_fail++; $display("FAIL restart_clear: product %0d expected 0", product);
    end
    tick(7);
    n_checks++;
    if (done !== 1'b1 || product !== 16'd30) begin
      n_fail++; $display("FAIL restart_result: done %0b product %0d expected 1/30", done, product);
    end
  endtask

  task automatic test_reset_mid_op;
    load_ops(16'd9, 16'd9);
    tick(3);
    n_checks++;
    if (product !== 16'd27) begin
      n_fail++; $display("FAIL midop_partial: product %0d expected 27", product);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++;
    if (dbg_state !== IDLE || done !== 1'b0 || product !== 16'd0) begin
      n_fail++;
      $display("FAIL midop_reset: state %0d done %0b product %0d expected IDLE/0/0",
               dbg_state, done, product);
    end
    load_ops(16'd2, 16'd3);
    tick(4);
    n_checks++;
    if (done !== 1'b1 || product !== 16'd6) begin
      n_fail++; $display("FAIL midop_fresh: done %0b product %0d expected 1/6", done, product);
    end
  endtask

  task automatic test_max_values;
    load_ops(16'd65535, 16'd1);
    tick(1);  // edge k+3
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL max_early_done: got %0b expected 0", done);
    end
    tick(1);  // edge k+4
    n_checks++;
    if (done !== 1'b1 || product !== 16'd65535) begin
      n_fail++; $display("FAIL max_result: done %0b product %0d expected 1/65535", done, product);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    #1;
    test_reset();
    test_basic();
    test_zero_operands();
    test_overflow();
    test_start_while_busy();
    test_reset_mid_op();
    test_max_values();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mul_top
